alu_cmd_sequencer: RTL and testbench

Upstream command stage for the 16-bit accumulator ALU. It accepts ALU commands (opcode, operands, load-select) over a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time to the ALU and holds the ALU inputs stable for the fixed ALU latency. It then captures the ALU result and returns it over a valid/ready response channel, adding error flagging for illegal opcodes and divide-by-zero.

---
 rtl/alu_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Buffers ALU commands in a FIFO, issues them one at a time to the
//            accumulator ALU, and returns results with error flagging.
// Revision : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 3,
    parameter int W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [3:0]              cmd_opcode,
    input  logic                    cmd_load,
    input  logic [W-1:0]            cmd_a,
    input  logic [W-1:0]            cmd_b,
    output logic [3:0]              alu_opcode,
    output logic                    alu_load,
    output logic [W-1:0]            alu_a,
    output logic [W-1:0]            alu_b,
    input  logic [W-1:0]            alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [W-1:0]            rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam int EW = 4 + 1 + 2 * W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [LW-1:0] C_WAIT_INIT = LW'(ALU_LAT - 1);
    localparam logic [CW-1:0] C_FULL      = CW'(DEPTH);
    localparam logic [3:0]    C_OP_DIV    = 4'b1000;

    logic [EW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [1:0]     r_state;
    logic [1:0]     w_next_state;
    logic [LW-1:0]  r_wait;
    logic [3:0]     r_alu_opcode;
    logic           r_alu_load;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_err;

    logic           w_push;
    logic           w_pop;
    logic [EW-1:0]  w_head;
    logic           w_illegal;

    assign cmd_ready  = (r_count != C_FULL);
    assign w_push     = cmd_valid && cmd_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_illegal  = (w_head[EW-1 -: 3] == 3'b111);

    assign fifo_count = r_count;
    assign alu_opcode = r_alu_opcode;
    assign alu_load   = r_alu_load;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_opcode, cmd_load, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_next_state = w_illegal ? S_RESP : S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (r_wait == '0) w_next_state = S_RESP;
            S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (r_state == S_RESP);
        busy      = (r_state != S_IDLE);
    end

    // Illegal opcodes bypass the ALU entirely, leaving its inputs untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_opcode <= '0;
            r_alu_load   <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_wait       <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_illegal) begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                        end else begin
                            r_alu_opcode <= w_head[EW-1 -: 4];
                            r_alu_load   <= w_head[2*W];
                            r_alu_a      <= w_head[2*W-1 -: W];
                            r_alu_b      <= w_head[W-1:0];
                        end
                    end
                end
                S_ISSUE: r_wait <= C_WAIT_INIT;
                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_rsp_data <= alu_result;
                        r_rsp_err  <= (r_alu_opcode == C_OP_DIV) && (r_alu_b == '0);
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Directed self-checking bench with a small latency-3 ALU model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic        cmd_load;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  alu_opcode;
    logic        alu_load;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [2:0]  fifo_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(3), .W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_load(cmd_load),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_opcode(alu_opcode), .alu_load(alu_load),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .fifo_count(fifo_count)
    );

    // ALU model: A-register edge, then accumulator edge.
    logic [15:0] m_areg = '0;
    logic [15:0] m_acc  = '0;
    assign alu_result = m_acc;
    always_ff @(posedge clk) begin
        m_areg <= alu_load ? alu_a : m_acc;
        case (alu_opcode)
            4'b0000: m_acc <= m_areg;
            4'b0001: m_acc <= m_areg & alu_b;
            4'b0101: m_acc <= m_areg | alu_b;
            4'b1000: m_acc <= (alu_b == 16'd0) ? 16'd0 : m_areg / alu_b;
            4'b1001: m_acc <= m_areg + alu_b;
            4'b1011: m_acc <= 16'(m_areg * alu_b);
            4'b1100: m_acc <= m_areg << 1;
            4'b1101: m_acc <= m_areg >> 1;
            default: m_acc <= 16'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".count"}, 32'(fifo_count), 32'd0);
        check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, ".alu"}, {alu_opcode, 11'd0, alu_load, alu_a}, 32'd0);
        check({tag, ".alu_b"}, 32'(alu_b), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    // Presents one command and returns once the push edge has passed.
    task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bit done = 0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_load   = 1'b1;
        cmd_a      = a;
        cmd_b      = b;
        for (int i = 0; i < 40 && !done; i++) begin
            if (cmd_ready) done = 1;
            step();
        end
        cmd_valid = 1'b0;
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_rsp(input string tag, input logic [15:0] d, input logic e);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (rsp_valid) seen = 1;
            else step();
        end
        check({tag, ".valid"}, 32'(seen), 32'd1);
        check({tag, ".data"}, 32'(rsp_data), 32'(d));
        check({tag, ".err"}, 32'(rsp_err), 32'(e));
        if (rsp_ready) step();
    endtask

    logic [3:0]  t_op  [5] = '{4'b1100, 4'b1101, 4'b0001, 4'b0101, 4'b1011};
    logic [15:0] t_a   [5] = '{16'd3, 16'd8, 16'd12, 16'd12, 16'd6};
    logic [15:0] t_b   [5] = '{16'd0, 16'd0, 16'd10, 16'd3, 16'd7};
    logic [15:0] t_exp [5] = '{16'd6, 16'd4, 16'd8, 16'd15, 16'd42};

    initial begin
        int  accepted;
        bit  leaked;
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_load = 1'b0;
        cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
        step(); step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();

        // Basic add: inspect latency and held ALU inputs.
        push(4'b1001, 16'd12, 16'd3);
        check("t1.count_after_push", 32'(fifo_count), 32'd1);
        step();
        check("t1.issue", {alu_opcode, 11'd0, alu_load, alu_a}, {4'b1001, 11'd0, 1'b1, 16'd12});
        check("t1.alu_b", 32'(alu_b), 32'd3);
        check("t1.busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("t1.no_rsp_edge%0d", k), 32'(rsp_valid), 32'd0);
            check($sformatf("t1.held_edge%0d", k), {alu_opcode, 11'd0, alu_load, alu_a}, {4'b1001, 11'd0, 1'b1, 16'd12});
        end
        step();
        check("t1.rsp_valid_edge4", 32'(rsp_valid), 32'd1);
        expect_rsp("t1", 16'd15, 1'b0);
        check("t1.rsp_dropped", 32'(rsp_valid), 32'd0);
        check("t1.idle", 32'(busy), 32'd0);

        // Divide by zero, then a legal divide.
        push(4'b1000, 16'd40, 16'd0);
        expect_rsp("div0", 16'd0, 1'b1);
        push(4'b1000, 16'd40, 16'd5);
        expect_rsp("div5", 16'd8, 1'b0);

        // Illegal opcode: response one edge after the pop, ALU untouched.
        push(4'b1110, 16'd7, 16'd7);
        step();
        check("ill.rsp_valid", 32'(rsp_valid), 32'd1);
        check("ill.alu_unchanged", {alu_opcode, 12'd0, alu_a}, {4'b1000, 12'd0, 16'd40});
        check("ill.alu_b_unchanged", 32'(alu_b), 32'd5);
        expect_rsp("ill", 16'd0, 1'b1);

        // Backpressure: five accepted, then full.
        rsp_ready = 1'b0;
        accepted  = 0;
        cmd_load  = 1'b1;
        for (int c = 0; c < 14; c++) begin
            cmd_valid  = 1'b1;
            cmd_opcode = (accepted < 5) ? t_op[accepted] : 4'b0000;
            cmd_a      = (accepted < 5) ? t_a[accepted]  : 16'd99;
            cmd_b      = (accepted < 5) ? t_b[accepted]  : 16'd99;
            if (cmd_ready) accepted++;
            step();
        end
        cmd_valid = 1'b0;
        check("bp.accepted", 32'(accepted), 32'd5);
        check("bp.cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp.count", 32'(fifo_count), 32'd4);
        rsp_ready = 1'b1;
        for (int r = 0; r < 5; r++) expect_rsp($sformatf("bp.rsp%0d", r), t_exp[r], 1'b0);

        // Push coinciding with a pop keeps the count at two.
        rsp_ready = 1'b0;
        push(4'b0000, 16'd1, 16'd0);
        push(4'b0000, 16'd5, 16'd0);
        push(4'b1001, 16'd20, 16'd1);
        expect_rsp("pp.x", 16'd1, 1'b0);
        check("pp.count_before", 32'(fifo_count), 32'd2);
        rsp_ready = 1'b1;
        step();
        check("pp.idle_after_hs", 32'(busy), 32'd0);
        push(4'b1101, 16'd100, 16'd0);
        check("pp.count_same", 32'(fifo_count), 32'd2);
        check("pp.busy", 32'(busy), 32'd1);
        expect_rsp("pp.y", 16'd5, 1'b0);
        expect_rsp("pp.z", 16'd21, 1'b0);
        expect_rsp("pp.w", 16'd50, 1'b0);

        // Asynchronous reset during WAIT with two entries queued.
        push(4'b1001, 16'd1, 16'd1);
        push(4'b1001, 16'd2, 16'd2);
        push(4'b1001, 16'd3, 16'd3);
        step();
        check("rst.queued", 32'(fifo_count), 32'd2);
        #3 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        step();
        rst = 1'b0;
        leaked = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid || busy) leaked = 1;
            step();
        end
        check("rst.no_response", 32'(leaked), 32'd0);
        check("rst.count_zero", 32'(fifo_count), 32'd0);
        push(4'b1011, 16'd9, 16'd9);
        expect_rsp("post_rst", 16'd81, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
